// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment width and
// active-low abcdefg glyphs for hex digits 0..F plus the all-dark pattern.
package seg7_pkg;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] GLYPH_0    = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1    = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2    = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3    = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4    = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5    = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6    = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7    = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9    = 7'b0000100;
  localparam logic [SEG_W-1:0] GLYPH_A    = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B    = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_C    = 7'b0110001;
  localparam logic [SEG_W-1:0] GLYPH_D    = 7'b1000010;
  localparam logic [SEG_W-1:0] GLYPH_E    = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_F    = 7'b0111000;
  localparam logic [SEG_W-1:0] GLYPH_NULL = 7'b1111111;
endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low abcdefg glyph (bit 6 = segment a).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] glyph_o
);
  always_comb begin
    glyph_o = GLYPH_NULL;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with guard band,
// 16-level PWM brightness and leading-zero suppression. SEG7_BLINK_EN adds blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100_000,
  parameter int GUARD_CYCLES = 4_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                    clk_100Mhz,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  input  logic                    lz_en,
  input  logic [3:0]              brightness,
  output logic [0:SEG_W-1]        seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);
  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int DIG_W  = $clog2(NUM_DIGITS);
  localparam int STEP   = (SLOT_CYCLES - GUARD_CYCLES) / 16;
  localparam int STEP_W = $clog2(STEP + 1);

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [DIG_W-1:0]  digit_idx_q, digit_idx_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [3:0]        phase_q, phase_d;
  logic              slot_wrap, last_digit, slot_start, in_guard, lit;

  logic [NUM_DIGITS-1:0][3:0] nib;
  logic [NUM_DIGITS-1:0]      lz_zero, blink_off;
  logic [3:0]                 nib_q, cur_nib, bright_q, cur_bright;
  logic                       dp_bit_q, cur_dp, blank_q, cur_blank, blank_now;
  logic [SEG_W-1:0]           glyph;

  logic [0:SEG_W-1]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d, frame_start_q, frame_start_d;

  assign nib        = digits;
  assign slot_wrap  = (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1));
  assign last_digit = (digit_idx_q == DIG_W'(NUM_DIGITS - 1));
  assign slot_start = (slot_cnt_q == '0);
  assign in_guard   = int'(slot_cnt_q) < GUARD_CYCLES;

  // lz_zero[i]: nibbles i..top are all zero
  always_comb begin
    lz_zero = '0;
    lz_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      lz_zero[i] = lz_zero[i+1] && (nib[i] == 4'd0);
  end

`ifdef SEG7_BLINK_EN
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
  logic [FRM_W-1:0] frame_cnt_q;
  logic             blink_phase_q;

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (slot_wrap && last_digit) begin
      if (frame_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end
  assign blink_off = blink_phase_q ? blink_mask : '0;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_FRAMES > 0);
  assign blink_off = '0;
`endif

  assign blank_now = blank_mask[digit_idx_q] | blink_off[digit_idx_q] |
                     (lz_en & lz_zero[digit_idx_q] & (digit_idx_q != '0));

  // Slot-start cycle uses the live inputs so GUARD_CYCLES=0 still shows the first cycle.
  assign cur_nib    = slot_start ? nib[digit_idx_q]   : nib_q;
  assign cur_dp     = slot_start ? dp_in[digit_idx_q] : dp_bit_q;
  assign cur_blank  = slot_start ? blank_now          : blank_q;
  assign cur_bright = slot_start ? brightness         : bright_q;

  seg7_hex_decode u_dec (
    .nibble_i (cur_nib),
    .glyph_o  (glyph)
  );

  always_comb begin
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (slot_wrap) digit_idx_d = last_digit ? '0 : digit_idx_q + 1'b1;
    step_d  = step_q;
    phase_d = phase_q;
    // Phase tracked incrementally instead of dividing slot_cnt
    if (int'(slot_cnt_d) <= GUARD_CYCLES) begin
      step_d  = '0;
      phase_d = '0;
    end else if (step_q == STEP_W'(STEP - 1)) begin
      step_d  = '0;
      phase_d = phase_q + 1'b1;
    end else begin
      step_d = step_q + 1'b1;
    end
  end

  always_comb begin
    lit           = !in_guard && (phase_q <= cur_bright) && !cur_blank;
    an_d          = lit ? ~(NUM_DIGITS'(1) << digit_idx_q) : '1;
    seg_d         = lit ? glyph : GLYPH_NULL;
    dp_d          = !(lit && cur_dp);
    frame_start_d = slot_start && (digit_idx_q == '0);
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      step_q        <= '0;
      phase_q       <= '0;
      nib_q         <= '0;
      dp_bit_q      <= 1'b0;
      blank_q       <= 1'b1;
      bright_q      <= '0;
      an_q          <= '1;
      seg_q         <= GLYPH_NULL;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      step_q        <= step_d;
      phase_q       <= phase_d;
      nib_q         <= cur_nib;
      dp_bit_q      <= cur_dp;
      blank_q       <= cur_blank;
      bright_q      <= cur_bright;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Slot-level scoreboard bench for seg7_scan_driver with shortened slots.
module tb_seg7_scan_driver;
  localparam int ND    = 4;
  localparam int SLOT  = 100;
  localparam int GUARD = 4;
  localparam int STEP  = (SLOT - GUARD) / 16;
  localparam int BLINK = 2;

  typedef struct {
    int         digit;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         on;
  } exp_slot_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   dig;
  logic [ND-1:0] dp_in_r, blank_r, blink_r;
  logic          lz_r;
  logic [3:0]    bright_r;
  logic [0:6]    seg;
  logic          dp, frame_start;
  logic [ND-1:0] an;

  int errors = 0;
  int checks = 0;
  exp_slot_t exp_q[$];

  logic [6:0] glyph_tb [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk_100Mhz (clk),
    .reset      (reset),
    .digits     (dig),
    .dp_in      (dp_in_r),
    .blank_mask (blank_r),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_r),
`endif
    .lz_en      (lz_r),
    .brightness (bright_r),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic push_slot(input int d, input logic [3:0] b, input bit blink_off);
    exp_slot_t e;
    logic [15:0] upper;
    logic [3:0] one;
    one = 4'b0001;
    upper = dig >> (4 * d);
    e.digit = d;
    e.an    = ~(one << d);
    e.seg   = glyph_tb[dig[d*4 +: 4]];
    e.dp    = ~dp_in_r[d];
    e.on    = (blank_r[d] || (lz_r && d != 0 && upper == 16'h0) || blink_off)
              ? 0 : STEP * (int'(b) + 1);
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    for (int d = 0; d < ND; d++) push_slot(d, bright_r, 1'b0);
  endtask

  task automatic run_slot(input int chg_at, input logic [3:0] chg_val);
    exp_slot_t e;
    int on_cnt, bad, fs_bad, first_on, exp_first;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: queue empty, got 0 entries, required >=1");
      return;
    end
    e = exp_q.pop_front();
    on_cnt = 0; bad = 0; fs_bad = 0; first_on = -1;
    for (int j = 0; j < SLOT; j++) begin
      @(posedge clk); #1;
      if (an !== 4'hF) begin
        on_cnt++;
        if (first_on < 0) first_on = j;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) bad++;
      end else if (seg !== 7'h7F || dp !== 1'b1) begin
        bad++;
      end
      if (frame_start !== (j == 0 && e.digit == 0)) fs_bad++;
      if (j == chg_at) bright_r = chg_val;
    end
    exp_first = (e.on > 0) ? GUARD : -1;
    checks += 4;
    if (on_cnt !== e.on) begin
      errors++;
      $display("FAIL on_time digit%0d: got %0d cycles, required %0d", e.digit, on_cnt, e.on);
    end
    if (bad !== 0) begin
      errors++;
      $display("FAIL pattern digit%0d: %0d bad cycles, required 0 (an=%b seg=%b dp=%b)",
               e.digit, bad, e.an, e.seg, e.dp);
    end
    if (fs_bad !== 0) begin
      errors++;
      $display("FAIL frame_start digit%0d: %0d bad cycles, required 0", e.digit, fs_bad);
    end
    if (first_on !== exp_first) begin
      errors++;
      $display("FAIL guard digit%0d: first on at %0d, required %0d", e.digit, first_on, exp_first);
    end
  endtask

  task automatic run_frame();
    for (int d = 0; d < ND; d++) run_slot(-1, 4'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    checks += 4;
    if (an !== 4'hF) begin errors++; $display("FAIL %s an: got %b, required 1111", tag, an); end
    if (seg !== 7'h7F) begin errors++; $display("FAIL %s seg: got %b, required 1111111", tag, seg); end
    if (dp !== 1'b1) begin errors++; $display("FAIL %s dp: got %b, required 1", tag, dp); end
    if (frame_start !== 1'b0) begin
      errors++; $display("FAIL %s frame_start: got %b, required 0", tag, frame_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; dig = 16'h0; dp_in_r = '0; blank_r = '0; blink_r = '0;
    lz_r = 1'b0; bright_r = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
  endtask

  task automatic test_full_bright();
    dig = 16'h1234; bright_r = 4'd15; dp_in_r = '0; blank_r = '0; lz_r = 1'b0;
    push_frame();
    run_frame();
  endtask

  task automatic test_brightness();
    bright_r = 4'd7;
    push_frame();
    run_frame();
    // change to 0 mid-slot of digit 0; takes effect from digit 1
    push_slot(0, 4'd7, 1'b0);
    for (int d = 1; d < ND; d++) push_slot(d, 4'd0, 1'b0);
    run_slot(50, 4'd0);
    for (int d = 1; d < ND; d++) run_slot(-1, 4'd0);
  endtask

  task automatic test_lz();
    bright_r = 4'd15; lz_r = 1'b1;
    dig = 16'h0007; push_frame(); run_frame();
    dig = 16'h0000; push_frame(); run_frame();
    dig = 16'h0100; push_frame(); run_frame();
  endtask

  task automatic test_dp_blank();
    lz_r = 1'b0; dig = 16'h1234; bright_r = 4'd15;
    dp_in_r = 4'b0010; blank_r = 4'b1000;
    push_frame(); run_frame();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      dig      = 16'($urandom) >> (4 * $urandom_range(3));
      dp_in_r  = 4'($urandom);
      blank_r  = 4'($urandom) & 4'($urandom);
      lz_r     = 1'($urandom_range(1));
      bright_r = 4'($urandom_range(15));
      push_frame();
      run_frame();
    end
  endtask

  task automatic test_reset_mid();
    dig = 16'h5A3C; dp_in_r = '0; blank_r = '0; lz_r = 1'b0; bright_r = 4'd15;
    push_slot(0, bright_r, 1'b0); push_slot(1, bright_r, 1'b0);
    run_slot(-1, 4'd0); run_slot(-1, 4'd0);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("reset_mid");
    reset = 1'b0;
    push_frame();
    run_frame();
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dig = 16'h1234; dp_in_r = '0; blank_r = '0; lz_r = 1'b0; bright_r = 4'd15;
    blink_r = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      push_slot(0, bright_r, ((f / BLINK) % 2) == 1);
      for (int d = 1; d < ND; d++) push_slot(d, bright_r, 1'b0);
      run_frame();
    end
    blink_r = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_bright();
    test_brightness();
    test_lz();
    test_dp_blank();
    test_back_to_back();
    test_reset_mid();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed N-digit seven-segment display driver, successor to the fixed 4-digit clock display controller. It scans NUM_DIGITS common-anode digits with hex decode, per-digit decimal points, per-digit blanking, leading-zero suppression, 16-level brightness and inter-digit ghosting guard. It sits between the clock/counter datapath and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4: digits scanned, 2..8.
- SLOT_CYCLES, 100_000: clocks per digit slot (1 ms at 100 MHz).
- GUARD_CYCLES, 4_000: all-anodes-off clocks at the start of each slot; (SLOT_CYCLES-GUARD_CYCLES) must be a multiple of 16.
- BLINK_FRAMES, 125: full scan frames per blink half-period (only with SEG7_BLINK_EN).

- clk_100Mhz in 1: single clock; all logic on its rising edge.
- reset in 1: synchronous, active-high.
- digits in 4*NUM_DIGITS: nibble i = hex value of digit i; digit 0 is rightmost, on an[0].
- dp_in in NUM_DIGITS: per-digit decimal point request, 1 = lit.
- blank_mask in NUM_DIGITS: 1 forces digit dark.
- lz_en in 1: leading-zero suppression enable.
- brightness in 4: duty level 0..15.
- seg out [0:6]: segments a..g, active low.
- dp out 1: decimal point, active low.
- an out NUM_DIGITS: anodes, active low.
- frame_start out 1: one-cycle pulse at the start of digit 0's slot.

## Operation
- Counters: slot_cnt 0..SLOT_CYCLES-1; digit_idx 0..NUM_DIGITS-1, increments when slot_cnt wraps, then wraps to 0.
- At slot_cnt==0 the block captures the slot's nibble, dp bit, blank decision and brightness into slot registers; mid-slot input changes take effect next slot.
- Blank decision for digit i: blank_mask[i], or lz_en with nibbles i..NUM_DIGITS-1 all zero and i != 0 (digit 0 is never LZ-suppressed), or blink-off (see Configuration).
- Phase within slot: guard while slot_cnt < GUARD_CYCLES; else p = (slot_cnt-GUARD_CYCLES)/((SLOT_CYCLES-GUARD_CYCLES)/16), 0..15.
- Anode i on only when digit_idx==i, not guard, p <= captured brightness, not blank. brightness 15 = full active window; 0 = 1/16.
- Hex decode (active low, abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- When no anode is on: seg=1111111, dp=1. dp=0 only with anode on and captured dp bit set.
- Reset mid-operation: counters and outputs return to reset values on the next edge; no partial slot completes.

## Timing
- Outputs registered; an/seg/dp/frame_start reflect counter state of the previous cycle (latency 1 clock).
- Reset values: an all 1, seg 1111111, dp 1, frame_start 0, slot_cnt 0, digit_idx 0.
- First cycle after reset release: slot 0 of digit 0 begins; frame_start high on the following edge.
- Frame = NUM_DIGITS*SLOT_CYCLES clocks (4 ms default, 250 Hz refresh).
- An anode never overlaps another; at least GUARD_CYCLES all-off clocks between consecutive digits (0 allowed if GUARD_CYCLES=0).

## Configuration
- SEG7_BLINK_EN defined: adds input blink_mask[NUM_DIGITS] and a frame counter toggling blink_phase every BLINK_FRAMES frames (default 1 Hz); digits with blink_mask set are blanked while blink_phase=1. blink_phase resets to 0 (visible).
- Undefined: no blink_mask port, no frame counter, no blink_phase; behaviour otherwise identical.

## Structure
- Package seg7_pkg: 7-bit glyph constants for 0..F and NULL (1111111), SEG_W=7.
- Sub-module seg7_hex_decode: combinational nibble -> glyph, instanced once on the captured nibble.

## Test plan
- Reset held 3 cycles -> an=1111, seg=1111111, dp=1, frame_start=0; release -> frame_start pulses once per 400_000 clocks.
- digits=0x1234, brightness=15, masks 0 -> an 1110 shows 4 (1001100), 1101 shows 3, 1011 shows 2, 0111 shows 1; each on 96_000 clocks after 4_000 dark.
- brightness=7 -> each anode on exactly 8*6_000=48_000 clocks per slot; change to 0 mid-slot -> applies next slot, 6_000 clocks.
- digits=0x0007, lz_en=1 -> digits 3..1 dark, digit 0 shows 0001111; digits=0x0000 -> digit 0 shows 0000001.
- dp_in=0010, blank_mask=1000 -> dp=0 only during digit 1 on-time; an[3] never low.
- Reset asserted mid-slot of digit 2 -> next edge all outputs at reset values; scan restarts at digit 0; with SEG7_BLINK_EN, blink_mask=0001 -> digit 0 dark for alternate 125-frame periods.
